// File: rtl/spi_cfg_pkg.sv
// spi_cfg_pkg: shared state encoding, ROM word layout and defaults for the SPI config sequencer
package spi_cfg_pkg;
  localparam int RST_HOLD_CYCLES_DEF = 2000;
  localparam int RST_WAIT_CYCLES_DEF = 200;
  localparam int NUM_CMDS_DEF = 368;
  localparam int ROM_AW = 9;
  localparam int WORD_W = 24;
  localparam int ADDR_MSB = 23;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;
  typedef enum logic [2:0] {
    ST_IDLE, ST_RST_HOLD, ST_RST_WAIT, ST_FETCH, ST_LOAD, ST_SEND, ST_WAIT_DONE, ST_DONE
  } seq_state_t;
  function automatic logic [WORD_W-1:0] pack_word(input logic [WORD_W-1:0] w);
    return {w[ADDR_MSB:ADDR_LSB], w[DATA_MSB:0]};
  endfunction
endpackage

// File: rtl/spi_cmd_rom.sv
// spi_cmd_rom: synchronous-read command store, contents loaded through the write port
module spi_cmd_rom
  import spi_cfg_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ROM_AW-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ROM_AW-1:0] addr,
  output logic [WORD_W-1:0] data
);
  logic [WORD_W-1:0] mem [2**ROM_AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    data <= mem[addr];
  end
endmodule

// File: rtl/spi_cfg_sequencer.sv
// spi_cfg_sequencer: resets the RF chip, then streams command ROM words to an SPI shifter
module spi_cfg_sequencer
  import spi_cfg_pkg::*;
#(
  parameter int RST_HOLD_CYCLES = RST_HOLD_CYCLES_DEF,
  parameter int RST_WAIT_CYCLES = RST_WAIT_CYCLES_DEF,
  parameter int NUM_CMDS        = NUM_CMDS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              rf_xreset_n,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  output logic              spi_req,
  output logic [WORD_W-1:0] spi_word,
  input  logic              spi_ready,
  input  logic              spi_done,
  output logic              busy,
  output logic              done,
  output logic [ROM_AW-1:0] cmd_count
);
  localparam int MAXC = RST_HOLD_CYCLES > RST_WAIT_CYCLES ? RST_HOLD_CYCLES : RST_WAIT_CYCLES;
  localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
  seq_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [ROM_AW-1:0] cmd_nxt;
  logic [WORD_W-1:0] word_nxt;
  logic last_cmd;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cmd_count <= '0;
      spi_word  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cmd_count <= cmd_nxt;
      spi_word  <= word_nxt;
    end
  end
  assign last_cmd = (cmd_count + 1'b1) == ROM_AW'(NUM_CMDS);
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cmd_nxt   = cmd_count;
    word_nxt  = spi_word;
    if (abort) state_nxt = ST_IDLE;
    else begin
      case (state)
        ST_IDLE, ST_DONE: if (start) begin
          state_nxt = ST_RST_HOLD;
          cnt_nxt   = CW'(RST_HOLD_CYCLES - 1);
          cmd_nxt   = '0;
        end
        ST_RST_HOLD: if (cnt == '0) begin
          state_nxt = ST_RST_WAIT;
          cnt_nxt   = CW'(RST_WAIT_CYCLES - 1);
        end else cnt_nxt = cnt - 1'b1;
        ST_RST_WAIT: if (cnt == '0) state_nxt = ST_FETCH;
                     else cnt_nxt = cnt - 1'b1;
        ST_FETCH: state_nxt = ST_LOAD;
        ST_LOAD: begin
          word_nxt  = pack_word(rom_data);
          state_nxt = ST_SEND;
        end
        ST_SEND: if (spi_ready) state_nxt = ST_WAIT_DONE;
        ST_WAIT_DONE: if (spi_done) begin
          cmd_nxt   = cmd_count + 1'b1;
          state_nxt = last_cmd ? ST_DONE : ST_FETCH;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end
  // abort masks the request combinationally so the shifter never takes a word from a dying run
  assign spi_req     = (state == ST_SEND) && !abort;
  assign rf_xreset_n = state != ST_RST_HOLD;
  assign busy        = !(state == ST_IDLE || state == ST_DONE);
  assign done        = state == ST_DONE;
  assign rom_addr    = cmd_count;
endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// tb_spi_cfg_sequencer: random shifter traffic against a run-level reference model
module tb_spi_cfg_sequencer;
  import spi_cfg_pkg::*;
  localparam int HOLD = 2000;
  localparam int WAITC = 200;
  localparam int N = 368;
  localparam int FIRST_REQ = HOLD + WAITC + 3;

  logic clk = 0, reset = 1, start = 0, abort = 0, spi_ready = 0, spi_done = 0, rom_we = 0;
  logic [8:0] rom_waddr = 0;
  logic [23:0] rom_wdata = 0;
  logic rf_xreset_n, spi_req, busy, done;
  logic [8:0] rom_addr, cmd_count;
  logic [23:0] rom_data, spi_word;

  always #5 clk = ~clk;

  spi_cfg_sequencer #(.RST_HOLD_CYCLES(HOLD), .RST_WAIT_CYCLES(WAITC), .NUM_CMDS(N)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .rf_xreset_n(rf_xreset_n),
    .rom_addr(rom_addr), .rom_data(rom_data), .spi_req(spi_req), .spi_word(spi_word),
    .spi_ready(spi_ready), .spi_done(spi_done), .busy(busy), .done(done), .cmd_count(cmd_count));

  spi_cmd_rom u_rom (.clk(clk), .we(rom_we), .waddr(rom_waddr), .wdata(rom_wdata),
    .addr(rom_addr), .data(rom_data));

  typedef struct {int cyc; bit xr; bit req; bit bsy;} tvec_t;
  tvec_t tbl[6];

  int checks = 0, failures = 0;
  logic [23:0] img [N];
  int m_count = 0, run_cyc = 0, accepts = 0, sh_lat = 0, bp_cnt = 0;
  bit m_run = 0, m_done = 0, m_waiting = 0, seen_req = 0, sh_busy = 0, tbl_on = 0;
  bit bp_arm = 0, bp_fin = 0, bp_force = 0, bp_drop = 0, bp_stable = 1;
  logic [23:0] bp_word = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input bit st = 0, input bit ab = 0, input bit fd = 0);
    @(negedge clk);
    start = st;
    abort = ab;
    spi_done = 0;
    if (sh_busy) begin
      if (sh_lat == 0) begin spi_done = 1; sh_busy = 0; end
      else sh_lat--;
    end else if (fd || $urandom_range(0, 15) == 0) spi_done = 1;
    bp_force = bp_arm && !bp_fin && m_run && !m_waiting && m_count == 3;
    spi_ready = !sh_busy && !bp_force && ($urandom_range(0, 3) != 0);
    #1;
    run_cyc++;
    chk("xreset_n", rf_xreset_n, !(m_run && run_cyc >= 1 && run_cyc <= HOLD));
    chk("busy", busy, m_run);
    chk("done", done, m_done);
    chk("cmd_count", cmd_count, m_count);
    if (!m_run || ab) chk("req_idle", spi_req, 0);
    if (tbl_on)
      foreach (tbl[i])
        if (tbl[i].cyc == run_cyc) begin
          chk("tbl_xreset_n", rf_xreset_n, tbl[i].xr);
          chk("tbl_req", spi_req, tbl[i].req);
          chk("tbl_busy", busy, tbl[i].bsy);
        end
    if (m_run && !seen_req && spi_req) begin
      seen_req = 1;
      chk("first_req_cycle", run_cyc, FIRST_REQ);
    end
    if (bp_force) begin
      if (spi_req) begin
        if (bp_cnt == 0) bp_word = spi_word;
        else if (spi_word !== bp_word) bp_stable = 0;
        bp_cnt++;
        if (bp_cnt == 50) bp_fin = 1;
      end else if (bp_cnt > 0) bp_drop = 1;
    end
    if (ab) begin
      m_run = 0;
      m_waiting = 0;
    end else begin
      if (st && !m_run) begin
        m_run = 1; m_done = 0; m_count = 0; m_waiting = 0;
        run_cyc = 0; seen_req = 0; accepts = 0;
      end else if (m_run && m_waiting && spi_done) begin
        m_count++;
        m_waiting = 0;
        if (m_count == N) begin m_run = 0; m_done = 1; end
      end
      if (spi_req && spi_ready) begin
        chk("word", spi_word, m_count < N ? img[m_count] : 24'h0);
        chk("rom_addr", rom_addr, m_count);
        m_waiting = 1;
        sh_busy = 1;
        sh_lat = $urandom_range(0, 5);
        accepts++;
      end
    end
  endtask

  task automatic run_until_done();
    int n = 0;
    while (!m_done && n < 30000) begin step(); n++; end
    step();
    chk("run_done", done, 1);
    chk("run_count", cmd_count, N);
    chk("run_accepts", accepts, N);
    chk("run_busy", busy, 0);
  endtask

  initial begin
    tbl[0] = '{1, 0, 0, 1};
    tbl[1] = '{HOLD, 0, 0, 1};
    tbl[2] = '{HOLD + 1, 1, 0, 1};
    tbl[3] = '{HOLD + WAITC, 1, 0, 1};
    tbl[4] = '{FIRST_REQ - 1, 1, 0, 1};
    tbl[5] = '{FIRST_REQ, 1, 1, 1};
    img[0] = 24'h00E101;
    img[1] = 24'h012A55;
    for (int i = 2; i < N; i++) img[i] = 24'($urandom);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      rom_we = 1; rom_waddr = 9'(i); rom_wdata = img[i];
    end
    @(negedge clk);
    rom_we = 0;
    #1;
    chk("rst_xreset_n", rf_xreset_n, 1);
    chk("rst_req", spi_req, 0);
    chk("rst_word", spi_word, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_count", cmd_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    reset = 0;
    step();
    // run 1: startup timing table and a 50-clock backpressure stall on command 3
    tbl_on = 1;
    bp_arm = 1;
    step(1);
    run_until_done();
    tbl_on = 0;
    bp_arm = 0;
    chk("bp_hold_cycles", bp_cnt, 50);
    chk("bp_no_drop", bp_drop, 0);
    chk("bp_word_stable", bp_stable, 1);
    // run 2: restart from DONE, abort while waiting on command 5
    step(1);
    begin
      int n = 0;
      while (!(m_run && m_waiting && m_count == 5) && n < 20000) begin step(); n++; end
      if (n >= 20000) begin
        checks++; failures++;
        $display("FAIL abort_point: never reached cmd 5 wait, count=%0d", cmd_count);
      end
    end
    step(0, 1);
    step();
    chk("abort_busy", busy, 0);
    chk("abort_req", spi_req, 0);
    chk("abort_count", cmd_count, 5);
    for (int i = 0; i < 10; i++) step();
    step(0, 0, 1);
    step();
    chk("abort_spurious_done", cmd_count, 5);
    step(1, 1);
    step();
    chk("start_abort_idle", busy, 0);
    // run 3: asynchronous reset during the RF reset hold
    step(1);
    for (int i = 0; i < 100; i++) step();
    chk("hold_xreset_n", rf_xreset_n, 0);
    @(negedge clk);
    #2 reset = 1;
    #1;
    chk("arst_xreset_n", rf_xreset_n, 1);
    chk("arst_req", spi_req, 0);
    chk("arst_word", spi_word, 0);
    chk("arst_rom_addr", rom_addr, 0);
    chk("arst_count", cmd_count, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    m_run = 0; m_done = 0; m_count = 0; m_waiting = 0; sh_busy = 0;
    step();
    step();
    @(negedge clk);
    reset = 0;
    // run 4 replays the full hold after reset; run 5 reruns from DONE
    step(1);
    run_until_done();
    step(1);
    run_until_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
